sip_shift_acc: RTL and testbench
================================

Name: sip_shift_acc

Overview:
- Sits directly downstream of the SIP dot-product adder tree.
- Each cycle, takes one signed per-bit-slice partial sum and shifts it left by the slice's significance. Accumulates the shifted terms over a multi-cycle group, which reconstructs full-precision dot products from 2-bit activation/weight slices.
- On the last slice of a group, presents one signed, saturated result on a valid/ready output port.

Parameters:
- BITS_IN, 16 (matches `BITS_SIP_DOT_ADDER`), width of the incoming signed partial sum.
- BITS_ACC, 32, width of the accumulator and of the output result.
- BITS_SHIFT, 4, width of the shift-amount input (maximum shift 2^BITS_SHIFT-1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  partial sum is presented this cycle.
- o_ready  output  1  block can accept a beat this cycle.
- i_sip_dot_adder  input  BITS_IN  signed partial sum from the adder tree.
- i_shift  input  BITS_SHIFT  left-shift amount (slice significance) for this beat.
- i_first  input  1  beat is the first slice of a group.
- i_last  input  1  beat is the last slice of a group.
- o_valid  output  1  result is held on o_psum.
- i_ready  input  1  consumer accepts the result this cycle.
- o_psum  output  BITS_ACC  signed accumulated result.
- o_sat  output  1  saturation occurred within the group that produced o_psum; qualified by o_valid.
- o_err  output  1  sticky protocol error flag.

Behaviour:
- Reset (rst=1 at a clock edge):
  - acc=0, state=IDLE, o_valid=0, o_psum=0, o_sat=0, o_err=0, internal group-saturation flag=0.
  - Reset mid-group discards the partial accumulation.
- Handshake:
  - A beat is accepted when i_valid & o_ready.
  - o_ready = ~(o_valid & ~i_ready). This is combinational and lets a new beat be accepted in the same cycle the held result drains.
  - Inputs are ignored when no beat is accepted.
  - An output transfer happens when o_valid & i_ready.
- Term computation:
  - term = sign-extend(i_sip_dot_adder) to BITS_ACC+1 bits, then arithmetic left shift by i_shift.
  - sum = (start ? 0 : acc) + term, computed at BITS_ACC+1 bits (plus shift headroom).
  - sum is saturated to the signed BITS_ACC range [-2^(BITS_ACC-1), 2^(BITS_ACC-1)-1].
  - Any clipping sets the group-saturation flag.
  - A shifted term that itself exceeds the range also saturates.
- States:
  - IDLE: no group open. An accepted beat has start=1 regardless of i_first. Next state is ACC, or stays IDLE if i_last.
  - ACC: group open. An accepted beat with i_first=0 has start=0. An accepted beat with i_first=1 restarts: start=1, the old accumulation and saturation flag are discarded, and o_err is set (sticky until rst).
- i_last on an accepted beat:
  - The saturated sum is loaded into o_psum and the saturation flag (including this beat) into o_sat.
  - o_valid=1 on the next cycle; acc and the flag clear; state becomes IDLE.
  - Latency is one cycle from the last beat's acceptance to o_valid.
- i_first & i_last on the same beat: single-beat group; o_psum = saturate(term).
- Output hold: o_psum and o_sat hold stable while o_valid & ~i_ready.
- o_valid drop: o_valid falls after a transfer unless a new last beat is accepted in the same cycle, in which case it stays 1 with the new data.
- Stall: non-last beats also stall while the output is full and undrained (o_ready=0), so group beat order is preserved.
- o_err only ever sets; it is never cleared except by rst.

Test Plan:
- Reset: assert rst for 2 cycles with i_valid=1 -> o_valid=0, o_psum=0, o_err=0, o_ready=1, no acceptance.
- 4-beat group: inputs 3, -1, 2, 1 with shifts 0, 2, 4, 6 and first on beat 0, last on beat 3 -> one cycle after beat 3, o_valid=1, o_psum=3-4+32+64=95, o_sat=0.
- Single beat: i_first=i_last=1, input -5, shift 3 -> o_psum=-40, o_valid for exactly one cycle with i_ready=1.
- Backpressure: i_ready=0 when a result is ready -> o_ready=0, o_psum held, next group's beats stalled. Raise i_ready -> transfer and same-cycle acceptance of the next beat; the second result follows correctly.
- Saturation: BITS_ACC=32, input 32767 shifted 15, repeated 3 beats -> o_psum=2147483647, o_sat=1. The following clean group has o_sat=0.
- Protocol error: i_first asserted mid-group after 2 beats -> o_err=1 sticky. The result equals only the restarted group's sum. o_err clears only on rst.

Source files
------------

// File: rtl/sip_shift_acc_if.sv
// Beat-input / result-output bundle of the SIP shift accumulator.
// The slave modport is the accumulator's view; master is the surrounding logic.
interface sip_shift_acc_if #(
  parameter int BITS_IN    = 16,
  parameter int BITS_ACC   = 32,
  parameter int BITS_SHIFT = 4
);
  // Upstream beat channel
  logic                  i_valid;
  logic                  o_ready;
  logic [BITS_IN-1:0]    i_sip_dot_adder;
  logic [BITS_SHIFT-1:0] i_shift;
  logic                  i_first;
  logic                  i_last;
  // Downstream result channel
  logic                  o_valid;
  logic                  i_ready;
  logic [BITS_ACC-1:0]   o_psum;
  logic                  o_sat;
  // Status
  logic                  o_err;

  modport slave (
    input  i_valid, i_sip_dot_adder, i_shift, i_first, i_last, i_ready,
    output o_ready, o_valid, o_psum, o_sat, o_err
  );

  modport master (
    output i_valid, i_sip_dot_adder, i_shift, i_first, i_last, i_ready,
    input  o_ready, o_valid, o_psum, o_sat, o_err
  );
endinterface

// File: rtl/sip_shift_acc.sv
// Shift-and-accumulate stage behind the SIP dot-product adder tree.
// Each accepted beat adds (partial_sum << shift) into a saturating
// accumulator; the last beat of a group emits one result on a
// single-entry valid/ready output register.
module sip_shift_acc #(
  parameter int BITS_IN    = 16,
  parameter int BITS_ACC   = 32,
  parameter int BITS_SHIFT = 4
) (
  input logic             clk,
  input logic             rst,
  sip_shift_acc_if.slave  bus
);

  // Wide enough that neither the shift nor the add can wrap before clipping.
  localparam int W = BITS_ACC + (2 ** BITS_SHIFT) + 1;

  localparam logic signed [W-1:0] SAT_MAX =
    {{(W - BITS_ACC + 1){1'b0}}, {(BITS_ACC - 1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN =
    {{(W - BITS_ACC + 1){1'b1}}, {(BITS_ACC - 1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_e;

  state_e                     state_q, state_d;
  logic signed [BITS_ACC-1:0] acc_q, acc_d;
  logic                       grp_sat_q, grp_sat_d;
  logic                       o_valid_q, o_valid_d;
  logic [BITS_ACC-1:0]        o_psum_q, o_psum_d;
  logic                       o_sat_q, o_sat_d;
  logic                       o_err_q, o_err_d;

  logic                       ready;
  logic                       accept;
  logic                       start;
  logic signed [W-1:0]        term;
  logic signed [W-1:0]        base;
  logic signed [W-1:0]        sum;
  logic                       clip;
  logic [BITS_ACC-1:0]        sum_sat;
  logic                       grp_sat_new;

  // State register: tracks whether a group is currently open.
  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a non-last beat opens/keeps a group, a last beat closes it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    if (accept) state_d = bus.i_last ? IDLE : ACC;
  end

  // FSM outputs: handshake and whether this beat starts a fresh accumulation.
  always_comb begin
    ready  = ~(o_valid_q & ~bus.i_ready);
    accept = bus.i_valid & ready;
    start  = (state_q == IDLE) | bus.i_first;
  end

  // Datapath: shifted term, widened sum, clip to the signed accumulator range.
  always_comb begin
    term        = $signed({{(W - BITS_IN){bus.i_sip_dot_adder[BITS_IN-1]}},
                           bus.i_sip_dot_adder}) <<< bus.i_shift;
    base        = start ? '0 : $signed({{(W - BITS_ACC){acc_q[BITS_ACC-1]}}, acc_q});
    sum         = base + term;
    clip        = 1'b0;
    sum_sat     = sum[BITS_ACC-1:0];
    if (sum > SAT_MAX) begin
      clip    = 1'b1;
      sum_sat = SAT_MAX[BITS_ACC-1:0];
    end else if (sum < SAT_MIN) begin
      clip    = 1'b1;
      sum_sat = SAT_MIN[BITS_ACC-1:0];
    end
    grp_sat_new = (~start & grp_sat_q) | clip;
  end

  // Next values for the accumulator, group flag, result register and error flag.
  always_comb begin
    acc_d     = acc_q;
    grp_sat_d = grp_sat_q;
    o_valid_d = o_valid_q;
    o_psum_d  = o_psum_q;
    o_sat_d   = o_sat_q;
    o_err_d   = o_err_q;
    if (o_valid_q && bus.i_ready) o_valid_d = 1'b0;
    if (accept) begin
      if ((state_q == ACC) && bus.i_first) o_err_d = 1'b1;
      if (bus.i_last) begin
        o_valid_d = 1'b1;
        o_psum_d  = sum_sat;
        o_sat_d   = grp_sat_new;
        acc_d     = '0;
        grp_sat_d = 1'b0;
      end else begin
        acc_d     = $signed(sum_sat);
        grp_sat_d = grp_sat_new;
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      grp_sat_q <= 1'b0;
      o_valid_q <= 1'b0;
      o_psum_q  <= '0;
      o_sat_q   <= 1'b0;
      o_err_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      grp_sat_q <= grp_sat_d;
      o_valid_q <= o_valid_d;
      o_psum_q  <= o_psum_d;
      o_sat_q   <= o_sat_d;
      o_err_q   <= o_err_d;
    end
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = o_valid_q;
  assign bus.o_psum  = o_psum_q;
  assign bus.o_sat   = o_sat_q;
  assign bus.o_err   = o_err_q;

endmodule

// File: tb/tb_sip_shift_acc.sv
// Scoreboard bench for sip_shift_acc: a driver feeds beats and pushes the
// model's expected group results; a monitor pops them on each output transfer.
module tb_sip_shift_acc;

  localparam int BITS_IN    = 16;
  localparam int BITS_ACC   = 32;
  localparam int BITS_SHIFT = 4;
  localparam longint ACC_MAX = (longint'(1) <<< (BITS_ACC - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (BITS_ACC - 1));

  typedef struct {
    longint psum;
    bit     sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  sip_shift_acc_if #(.BITS_IN(BITS_IN), .BITS_ACC(BITS_ACC), .BITS_SHIFT(BITS_SHIFT)) bus ();

  sip_shift_acc #(.BITS_IN(BITS_IN), .BITS_ACC(BITS_ACC), .BITS_SHIFT(BITS_SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  exp_t   sb_q[$];
  longint last_psum = 0;
  int     rdy_mode  = 0;  // 0: always ready, 1: stalled, 2: random

  // Reference model state: running group sum and saturation flag.
  bit     mdl_open = 0;
  longint mdl_acc  = 0;
  bit     mdl_sat  = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint clip(input longint v, inout bit sat);
    if (v > ACC_MAX) begin sat = 1; return ACC_MAX; end
    if (v < ACC_MIN) begin sat = 1; return ACC_MIN; end
    return v;
  endfunction

  // Apply one accepted beat to the model: value * 2^shift added, then clipped.
  task automatic model_accept(input int x, input int s, input bit first, input bit last);
    exp_t e;
    if (!mdl_open || first) begin
      mdl_acc = 0;
      mdl_sat = 0;
    end
    mdl_acc = clip(mdl_acc + longint'(x) * (longint'(1) <<< s), mdl_sat);
    if (last) begin
      e.psum = mdl_acc;
      e.sat  = mdl_sat;
      sb_q.push_back(e);
      mdl_open = 0;
    end else begin
      mdl_open = 1;
    end
  endtask

  // Present one beat and hold it until accepted. Entered and left at posedge+1.
  task automatic send_beat(input int x, input int s, input bit first, input bit last);
    bus.i_valid         = 1'b1;
    bus.i_sip_dot_adder = BITS_IN'(x);
    bus.i_shift         = BITS_SHIFT'(s);
    bus.i_first         = first;
    bus.i_last          = last;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        model_accept(x, s, first, last);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("beat_accept_timeout", 0, 1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500; n++) begin
      if (sb_q.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    check("drain_timeout", sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Output-side ready driver.
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = 1'b0;
        default: bus.i_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare each transferred result, and check hold while stalled.
  initial begin
    exp_t   e;
    bit     held = 0;
    longint held_psum = 0;
    bit     held_sat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          check("hold_valid", bus.o_valid, 1);
          check("hold_psum", $signed(bus.o_psum), held_psum);
          check("hold_sat", bus.o_sat, held_sat);
        end
        held = bus.o_valid && !bus.i_ready;
        held_psum = $signed(bus.o_psum);
        held_sat  = bus.o_sat;
        if (bus.o_valid && bus.i_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_result", $signed(bus.o_psum), 0);
            check("unexpected_result_count", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("psum", $signed(bus.o_psum), e.psum);
            check("sat", bus.o_sat, e.sat);
          end
          last_psum = $signed(bus.o_psum);
        end
      end
    end
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_sip_dot_adder = '0;
    bus.i_shift = '0;
    bus.i_first = 1'b0;
    bus.i_last = 1'b0;

    // Reset with a beat offered: nothing may be accepted.
    rst = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_sip_dot_adder = BITS_IN'(9);
    bus.i_first = 1'b1;
    bus.i_last = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_o_valid", bus.o_valid, 0);
    check("rst_o_psum", bus.o_psum, 0);
    check("rst_o_sat", bus.o_sat, 0);
    check("rst_o_err", bus.o_err, 0);
    check("rst_o_ready", bus.o_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    check("post_rst_no_result", bus.o_valid, 0);
    @(posedge clk); #1;

    // Four-beat group: 3 - 4 + 32 + 64.
    send_beat(3, 0, 1, 0);
    send_beat(-1, 2, 0, 0);
    send_beat(2, 4, 0, 0);
    send_beat(1, 6, 0, 1);
    drain();
    check("group4_value", last_psum, 95);

    // Single-beat group.
    send_beat(-5, 3, 1, 1);
    drain();
    check("single_value", last_psum, -40);

    // Backpressure: first result held, next group stalled, then released.
    rdy_mode = 1;
    send_beat(7, 1, 1, 1);
    fork
      begin
        send_beat(1, 0, 1, 0);
        send_beat(2, 1, 0, 1);
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_o_ready_low", bus.o_ready, 0);
        check("bp_psum_held", $signed(bus.o_psum), 14);
        rdy_mode = 0;
      end
    join
    drain();
    check("bp_second_value", last_psum, 5);

    // Saturation, then a clean group.
    for (int k = 0; k < 3; k++) send_beat(32767, 15, k == 0, k == 2);
    drain();
    check("sat_value", last_psum, ACC_MAX);
    send_beat(4, 0, 1, 0);
    send_beat(4, 1, 0, 1);
    drain();
    check("clean_after_sat", last_psum, 12);

    // Protocol error: restart mid-group.
    check("err_before", bus.o_err, 0);
    send_beat(10, 0, 1, 0);
    send_beat(20, 0, 0, 0);
    send_beat(5, 1, 1, 0);
    send_beat(7, 0, 0, 1);
    drain();
    check("err_restart_value", last_psum, 17);
    check("err_set", bus.o_err, 1);

    // Randomised groups with random backpressure and gaps.
    rdy_mode = 2;
    for (int g = 0; g < 40; g++) begin
      int len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        int x = $signed(16'($urandom()));
        int s = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
        send_beat(x, s, b == 0, b == len - 1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    rdy_mode = 0;
    drain();
    check("err_sticky", bus.o_err, 1);

    // Reset mid-group discards the partial sum and clears the error.
    send_beat(100, 0, 1, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_open = 0;
    @(negedge clk);
    check("err_cleared", bus.o_err, 0);
    @(posedge clk); #1;
    send_beat(1, 0, 0, 1);
    drain();
    check("post_rst_group", last_psum, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
